// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller and decoder:
// state encodings, Control_Word field offsets and branch_select codes.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

  localparam int CW_W         = 36;
  localparam int CW_BR_LSB    = 32;
  localparam int CW_SLT       = 31;
  localparam int CW_IMM_LSB   = 28;
  localparam int CW_WSTRB_LSB = 26;
  localparam int CW_MUXD      = 25;
  localparam int CW_RS2_LSB   = 20;
  localparam int CW_RS1_LSB   = 15;
  localparam int CW_F3_LSB    = 12;
  localparam int CW_RD_LSB    = 7;
  localparam int CW_FSEL_LSB  = 3;
  localparam int CW_MUXB      = 2;
  localparam int CW_REGRW     = 1;
  localparam int CW_MEMRW     = 0;

  localparam logic [3:0] BS_BR    = 4'b0001;
  localparam logic [3:0] BS_AUIPC = 4'b0010;
  localparam logic [3:0] BS_JAL   = 4'b0100;
  localparam logic [3:0] BS_JALR  = 4'b1000;

  // Jumps always redirect; conditional branches only when the comparator agrees.
  function automatic logic take_target(input logic [3:0] bs, input logic taken);
    return (bs == BS_JAL) || (bs == BS_JALR) || ((bs == BS_BR) && taken);
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive un-acked request cycles; flags timeout on the last
// allowed cycle so the controller can leave the request state that edge.
module ack_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ack,
  output logic timeout
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    timeout = busy && !ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d   = cnt_q + CNT_W'(1);
    if (!busy || ack || timeout) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// handshake memories and a retire counter. MEM_TIMEOUT_EN adds an ack watchdog.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Halt,
  input  logic [35:0]         Control_Word,
  input  logic                Branch_Taken,
  input  logic                Imem_Ack,
  input  logic                Dmem_Ack,
  output logic                Imem_Req,
  output logic                Dmem_Req,
  output logic                Dmem_We,
  output logic                IR_Write,
  output logic                PC_Write,
  output logic                PC_Select,
  output logic                Reg_Write_En,
  output logic [35:0]         CW_Q,
  output logic [2:0]          State,
  output logic [RETIRE_W-1:0] Retire_Count,
  output logic                Bus_Error
);

  state_e              state_q, state_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic                pc_sel_q, pc_sel_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                bus_err_q, bus_err_d;
  logic                timeout;
  logic                is_mem, is_store, jump_now;

  assign is_mem   = cw_q[CW_MEMRW] | cw_q[CW_MUXD];
  assign is_store = cw_q[CW_MEMRW];
  assign jump_now = take_target(cw_q[CW_BR_LSB +: 4], Branch_Taken);

`ifdef MEM_TIMEOUT_EN
  logic mem_ack;
  assign mem_ack = (Imem_Req & Imem_Ack) | (Dmem_Req & Dmem_Ack);

  ack_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (Imem_Req | Dmem_Req),
    .ack     (mem_ack),
    .timeout (timeout)
  );
`else
  // Without the watchdog the limit is unused and a request waits forever.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cw_q      <= '0;
      pc_sel_q  <= 1'b0;
      retire_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cw_q      <= cw_d;
      pc_sel_q  <= pc_sel_d;
      retire_q  <= retire_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state. PC_Write marks the retire cycle of every instruction.
  always_comb begin
    state_d   = state_q;
    cw_d      = cw_q;
    pc_sel_d  = pc_sel_q;
    retire_d  = retire_q;
    bus_err_d = bus_err_q | timeout;
    case (state_q)
      ST_IDLE:      if (!Halt) state_d = ST_FETCH;
      ST_FETCH: begin
        if (Imem_Ack)     state_d = ST_DECODE;
        else if (timeout) state_d = ST_ERROR;
      end
      ST_DECODE: begin
        cw_d    = Control_Word;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        pc_sel_d = jump_now;
        if (is_mem)               state_d = ST_MEMORY;
        else if (cw_q[CW_REGRW])  state_d = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (Dmem_Ack && !is_store) state_d = ST_WRITEBACK;
        else if (!Dmem_Ack && timeout) state_d = ST_ERROR;
      end
      ST_WRITEBACK: state_d = ST_WRITEBACK;
      ST_ERROR:     state_d = ST_ERROR;
      default:      state_d = ST_IDLE;
    endcase
    if (PC_Write) begin
      retire_d = retire_q + RETIRE_W'(1);
      pc_sel_d = 1'b0;
      state_d  = Halt ? ST_IDLE : ST_FETCH;
    end
  end

  // Strobes are decoded from state; the ack-dependent ones are qualified by the ack.
  always_comb begin
    Imem_Req     = 1'b0;
    Dmem_Req     = 1'b0;
    Dmem_We      = 1'b0;
    IR_Write     = 1'b0;
    PC_Write     = 1'b0;
    Reg_Write_En = 1'b0;
    PC_Select    = pc_sel_q;
    case (state_q)
      ST_FETCH: begin
        Imem_Req = 1'b1;
        IR_Write = Imem_Ack;
      end
      ST_EXECUTE: begin
        PC_Select = jump_now;
        PC_Write  = !is_mem && !cw_q[CW_REGRW];
      end
      ST_MEMORY: begin
        Dmem_Req = 1'b1;
        Dmem_We  = is_store;
        PC_Write = is_store && Dmem_Ack;
      end
      ST_WRITEBACK: begin
        Reg_Write_En = 1'b1;
        PC_Write     = 1'b1;
      end
      default: ;
    endcase
  end

  assign CW_Q         = cw_q;
  assign State        = state_q;
  assign Retire_Count = retire_q;
  assign Bus_Error    = bus_err_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table,
// hand sequences for halt/reset, and randomized instructions vs a trace model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n, Halt, Branch_Taken, Imem_Ack, Dmem_Ack;
  logic [35:0] Control_Word;
  logic        Imem_Req, Dmem_Req, Dmem_We, IR_Write, PC_Write, PC_Select, Reg_Write_En;
  logic [35:0] CW_Q;
  logic [2:0]  State;
  logic [31:0] Retire_Count;
  logic        Bus_Error;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned model_retire = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Halt(Halt), .Control_Word(Control_Word),
    .Branch_Taken(Branch_Taken), .Imem_Ack(Imem_Ack), .Dmem_Ack(Dmem_Ack),
    .Imem_Req(Imem_Req), .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We), .IR_Write(IR_Write),
    .PC_Write(PC_Write), .PC_Select(PC_Select), .Reg_Write_En(Reg_Write_En),
    .CW_Q(CW_Q), .State(State), .Retire_Count(Retire_Count), .Bus_Error(Bus_Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] mk_cw(input logic [3:0] bs, input logic muxd,
                                        input logic regrw, input logic memrw);
    return {bs, 1'b0, 3'd0, 2'b11, muxd, 5'd2, 5'd1, 3'd2, 5'd3, 4'd5, 1'b1, regrw, memrw};
  endfunction

  function automatic logic [35:0] rnd36();
    return 36'({$urandom(), $urandom()});
  endfunction

  // One instruction, entered at a negedge with the DUT in FETCH. The expected
  // per-cycle trace is built from the phase list: F*(iw+1), D, E, [M*(dw+1)], [WB].
  task automatic run_instr(input logic [35:0] cw, input logic taken, input int iw,
                           input int dw, input logic halt_end,
                           output int cycles, output logic pcsel_ret);
    logic [8:0] exp_q[$];
    logic [3:0] bs;
    logic       is_mem, store, wb, jump;
    int         ex_idx, icnt, dcnt, last;
    bs     = cw[35:32];
    store  = cw[0];
    is_mem = cw[0] | cw[25];
    wb     = is_mem ? !store : cw[1];
    jump   = (bs == 4'b0100) || (bs == 4'b1000) || (bs == 4'b0001 && taken);
    for (int i = 0; i <= iw; i++) exp_q.push_back({3'd1, 1'b1, i == iw, 4'b0000});
    exp_q.push_back({3'd2, 6'b000000});
    ex_idx = exp_q.size();
    exp_q.push_back({3'd3, 5'b00000, !is_mem && !wb});
    if (is_mem)
      for (int i = 0; i <= dw; i++)
        exp_q.push_back({3'd4, 2'b00, 1'b1, store, 1'b0, store && (i == dw)});
    if (wb) exp_q.push_back({3'd5, 4'b0000, 2'b11});
    last      = exp_q.size() - 1;
    cycles    = -1;
    pcsel_ret = 1'bx;
    icnt      = 0;
    dcnt      = 0;
    for (int k = 0; k <= last; k++) begin
      Imem_Ack     = Imem_Req ? (icnt == iw) : 1'($urandom_range(0, 1));
      Dmem_Ack     = Dmem_Req ? (dcnt == dw) : 1'($urandom_range(0, 1));
      if (Imem_Req) icnt++;
      if (Dmem_Req) dcnt++;
      Control_Word = (k == iw + 1) ? cw : rnd36();
      Branch_Taken = (k == ex_idx) ? taken : 1'($urandom_range(0, 1));
      Halt         = (k == last) ? halt_end : (k > iw) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check($sformatf("cyc%0d state/strobes", k),
            64'({State, Imem_Req, IR_Write, Dmem_Req, Dmem_We, Reg_Write_En, PC_Write}),
            64'(exp_q[k]));
      check($sformatf("cyc%0d bus_error", k), 64'(Bus_Error), 64'(0));
      if (k >= ex_idx) begin
        check($sformatf("cyc%0d cw_q", k), 64'(CW_Q), 64'(cw));
        check($sformatf("cyc%0d pc_select", k), 64'(PC_Select), 64'(jump));
      end
      if (PC_Write && cycles < 0) begin
        cycles    = k + 1;
        pcsel_ret = PC_Select;
      end
      @(negedge clk);
    end
    model_retire++;
    #1;
    check("retire_count", 64'(Retire_Count), 64'(model_retire));
  endtask

  task automatic idle_hold(input int n);
    Halt = 1'b1;
    for (int i = 0; i < n; i++) begin
      Imem_Ack = 1'($urandom_range(0, 1));
      #1;
      check("halted state", 64'(State), 64'(0));
      check("halted imem_req", 64'(Imem_Req), 64'(0));
      @(negedge clk);
    end
    Halt = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [35:0] cw;
    logic        taken;
    int          iw, dw;
    int          exp_cyc;
    logic        exp_pcsel;
  } vec_t;

  initial begin
    vec_t        vt[10];
    int          cyc;
    logic        ps;
    logic [35:0] cw;
    logic        hend;

    vt[0] = '{"ADD",     mk_cw(4'b0000, 0, 1, 0), 1'b0, 0, 0, 4, 1'b0};
    vt[1] = '{"BEQ_T",   mk_cw(4'b0001, 0, 0, 0), 1'b1, 0, 0, 3, 1'b1};
    vt[2] = '{"BEQ_N",   mk_cw(4'b0001, 0, 0, 0), 1'b0, 0, 0, 3, 1'b0};
    vt[3] = '{"LW_D3",   mk_cw(4'b0000, 1, 1, 0), 1'b0, 0, 3, 8, 1'b0};
    vt[4] = '{"SW",      mk_cw(4'b0000, 0, 0, 1), 1'b0, 0, 0, 4, 1'b0};
    vt[5] = '{"JAL",     mk_cw(4'b0100, 0, 1, 0), 1'b0, 0, 0, 4, 1'b1};
    vt[6] = '{"JALR_I2", mk_cw(4'b1000, 0, 1, 0), 1'b0, 2, 0, 6, 1'b1};
    vt[7] = '{"AUIPC",   mk_cw(4'b0010, 0, 1, 0), 1'b1, 0, 0, 4, 1'b0};
    vt[8] = '{"BR_I1",   mk_cw(4'b0001, 0, 0, 0), 1'b1, 1, 0, 4, 1'b1};
    vt[9] = '{"SW_D2",   mk_cw(4'b0000, 0, 0, 1), 1'b0, 0, 2, 6, 1'b0};

    rst_n = 1'b0; Halt = 1'b0; Branch_Taken = 1'b0; Imem_Ack = 1'b0; Dmem_Ack = 1'b0;
    Control_Word = '0;
    #12;
    check("reset state", 64'(State), 64'(0));
    check("reset strobes",
          64'({Imem_Req, Dmem_Req, Dmem_We, IR_Write, PC_Write, PC_Select, Reg_Write_En}), 64'(0));
    check("reset cw_q", 64'(CW_Q), 64'(0));
    check("reset retire", 64'(Retire_Count), 64'(0));
    check("reset bus_error", 64'(Bus_Error), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      run_instr(vt[i].cw, vt[i].taken, vt[i].iw, vt[i].dw, 1'b0, cyc, ps);
      check({vt[i].name, " cycles"}, 64'(cyc), 64'(vt[i].exp_cyc));
      check({vt[i].name, " pc_select@retire"}, 64'(ps), 64'(vt[i].exp_pcsel));
    end

    // Store with Halt asserted from EXECUTE: retires, then parks in IDLE.
    run_instr(mk_cw(4'b0000, 0, 0, 1), 1'b0, 0, 1, 1'b1, cyc, ps);
    check("SW_HALT cycles", 64'(cyc), 64'(5));
    idle_hold(3);

    // Reset pulse while a load waits on Dmem_Ack.
    Imem_Ack = 1'b1; Dmem_Ack = 1'b0; Halt = 1'b0;
    @(negedge clk);
    Imem_Ack = 1'b0; Control_Word = mk_cw(4'b0000, 1, 1, 0);
    @(negedge clk);
    Control_Word = rnd36();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre-reset state", 64'(State), 64'(4));
    check("pre-reset dmem_req", 64'(Dmem_Req), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst state", 64'(State), 64'(0));
    check("rst dmem_req", 64'(Dmem_Req), 64'(0));
    check("rst strobes", 64'({PC_Write, Reg_Write_En, IR_Write, Imem_Req}), 64'(0));
    check("rst retire", 64'(Retire_Count), 64'(0));
    model_retire = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst idle", 64'(State), 64'(0));
    @(negedge clk);

    // Random instructions with random wait states against the trace model.
    for (int n = 0; n < 60; n++) begin
      cw = rnd36();
      case ($urandom_range(0, 5))
        0: begin cw[35:32] = 4'b0000; cw[25] = 1'b0; cw[1] = 1'b1; cw[0] = 1'b0; end
        1: begin cw[35:32] = 4'b0001; cw[25] = 1'b0; cw[1] = 1'b0; cw[0] = 1'b0; end
        2: begin cw[35:32] = 4'b0000; cw[25] = 1'b1; cw[1] = 1'b1; cw[0] = 1'b0; end
        3: begin cw[35:32] = 4'b0000; cw[1]  = 1'b0; cw[0] = 1'b1; end
        4: begin cw[35:32] = ($urandom_range(0, 1) != 0) ? 4'b0100 : 4'b1000;
                 cw[25] = 1'b0; cw[1] = 1'b1; cw[0] = 1'b0; end
        default: begin cw[35:32] = 4'b0010; cw[25] = 1'b0; cw[1] = 1'b1; cw[0] = 1'b0; end
      endcase
      hend = ($urandom_range(0, 7) == 0);
      run_instr(cw, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                hend, cyc, ps);
      if (hend) idle_hold($urandom_range(1, 3));
    end

`ifdef MEM_TIMEOUT_EN
    // Fetch that is never acked: ERROR after 16 request cycles, sticky until reset.
    Imem_Ack = 1'b0; Dmem_Ack = 1'b0; Halt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("to req%0d", i), 64'({State, Imem_Req}), 64'({3'd1, 1'b1}));
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      Imem_Ack = 1'($urandom_range(0, 1));
      #1;
      check("to state", 64'(State), 64'(6));
      check("to bus_error", 64'(Bus_Error), 64'(1));
      check("to req dropped", 64'({Imem_Req, Dmem_Req}), 64'(0));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("to reset clears", 64'({State, Bus_Error}), 64'(0));
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
